rom_seq_reader: RTL and testbench

//  Sequencer that sits directly upstream of rom_8x4. It drives rom_8x4's combinational

---
 rtl/rom_seq_reader_if.sv | 35 +++
 rtl/rom_seq_reader.sv | 104 ++++++++++
 tb/tb_rom_seq_reader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rom_seq_reader_if.sv
// rtl/rom_seq_reader_if.sv - ROM lookup port and tagged output word stream of the ROM sequencer
interface rom_seq_reader_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  // Sequencer side: drives the ROM address and produces the stream.
  modport master (
    output rom_addr,
    input  rom_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_last
  );

  // ROM plus downstream consumer side.
  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_last
  );
endinterface

// File: rtl/rom_seq_reader.sv
// rtl/rom_seq_reader.sv - walks consecutive ROM addresses and streams each word with address, last flag and running sum
module rom_seq_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          len,
  rom_seq_reader_if.master         bus,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] sum
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                     state;
  logic [ADDR_W:0]            remaining;
  logic [ADDR_W-1:0]          rom_addr_q;
  logic                       out_valid_q;
  logic [DATA_W-1:0]          out_data_q;
  logic [ADDR_W-1:0]          out_addr_q;
  logic                       out_last_q;
  logic [DATA_W+ADDR_W-1:0]   sum_q;

  assign bus.rom_addr  = rom_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;
  assign sum           = sum_q;

  // Status flags are pure decodes of the registered state.
  assign busy = (state != IDLE);
  assign done = (state == FIN);

  // Transfer sequencer: one ROM read per FETCH, held in OUT until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      rom_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      sum_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum_q <= '0;
            if (len != '0) begin
              rom_addr_q <= base_addr;
              // Requests longer than the ROM are clamped to a single full sweep.
              remaining  <= (len > DEPTH_CNT) ? DEPTH_CNT : len;
              state      <= FETCH;
            end else begin
              state      <= FIN;
            end
          end
        end
        FETCH: begin
          // rom_addr has been stable for a full cycle, so the combinational ROM output is settled.
          out_data_q  <= bus.rom_data;
          out_addr_q  <= rom_addr_q;
          out_valid_q <= 1'b1;
          out_last_q  <= (remaining == 1);
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            sum_q       <= sum_q + {{ADDR_W{1'b0}}, out_data_q};
            out_valid_q <= 1'b0;
            if (remaining == 1) begin
              state <= FIN;
            end else begin
              remaining  <= remaining - 1'b1;
              // Address arithmetic is modulo the ROM depth by width.
              rom_addr_q <= rom_addr_q + 1'b1;
              state      <= FETCH;
            end
          end
        end
        FIN: begin
          out_last_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_seq_reader.sv
// tb/tb_rom_seq_reader.sv - directed self-checking bench for rom_seq_reader with an addr+8 ROM model
module tb_rom_seq_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] len;
  logic       busy;
  logic       done;
  logic [6:0] sum;

  int n_cmp;
  int n_err;

  rom_seq_reader_if #(.ADDR_W(3), .DATA_W(4)) bus ();

  // ROM model: word = address + 8.
  assign bus.rom_data = {1'b1, bus.rom_addr};

  rom_seq_reader #(.ADDR_W(3), .DATA_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transfer; optional stall of stall_cyc cycles on beat index stall_beat and
  // optional start pulse at loop cycle poke_cyc while busy.
  task automatic run_xfer(input string name, input int base, input int ln,
                          input int stall_beat, input int stall_cyc,
                          input int poke_cyc, input int exp_sum);
    int  n;
    int  beats;
    int  dones;
    int  cyc;
    int  first;
    int  last_cyc;
    int  stall_left;
    int  ea;
    bit  fin;
    n = (ln > 8) ? 8 : ln;
    beats = 0; dones = 0; cyc = 0; first = -1; last_cyc = -1;
    stall_left = stall_cyc; fin = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 3'(base); len = 4'(ln); bus.out_ready = 1'b1;
    while (!fin && cyc < 80) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == poke_cyc) begin
        start = 1'b1; base_addr = 3'(base + 3); len = 4'd2;
      end
      if (bus.out_valid) begin
        if (first < 0) first = cyc;
        ea = (base + beats) % 8;
        if (beats == stall_beat && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
          check({name, " held_addr"}, bus.out_addr, ea);
          check({name, " held_data"}, bus.out_data, ea + 8);
        end else begin
          bus.out_ready = 1'b1;
        end
        if (bus.out_ready) begin
          if (stall_cyc == 0 && beats > 0) check({name, " spacing"}, cyc - last_cyc, 2);
          check({name, " addr"}, bus.out_addr, ea);
          check({name, " data"}, bus.out_data, ea + 8);
          check({name, " last"}, bus.out_last, (beats == n - 1));
          beats++;
          last_cyc = cyc;
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      if (done) begin
        dones++;
        fin = 1'b1;
      end
    end
    check({name, " finished"}, fin, 1);
    check({name, " beats"}, beats, n);
    check({name, " done_pulses"}, dones, 1);
    check({name, " first_valid"}, first, (n > 0) ? 2 : -1);
    if (n == 0) check({name, " done_latency"}, cyc, 1);
    check({name, " sum"}, sum, exp_sum);
    @(negedge clk);
    check({name, " idle_busy"}, busy, 0);
    check({name, " idle_done"}, done, 0);
    check({name, " sum_hold"}, sum, exp_sum);
  endtask

  initial begin
    int beats;
    int cyc;
    int vcnt;
    int dcnt;
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst valid", bus.out_valid, 0);
    check("rst rom_addr", bus.rom_addr, 0);
    check("rst sum", sum, 0);
    check("rst done", done, 0);
    rst = 1'b0;

    run_xfer("full", 0, 8, -1, 0, 0, 92);
    check("full rom_addr_hold", bus.rom_addr, 7);
    run_xfer("wrap", 6, 4, -1, 0, 0, 46);
    run_xfer("stall", 2, 3, 1, 5, 0, 33);
    run_xfer("len0", 3, 0, -1, 0, 0, 0);
    run_xfer("clamp", 5, 12, -1, 0, 0, 13 + 14 + 15 + 8 + 9 + 10 + 11 + 12);
    run_xfer("ignore_start", 1, 4, -1, 0, 3, 9 + 10 + 11 + 12);

    // Reset in the middle of a full sweep, after the third beat is taken.
    @(negedge clk);
    start = 1'b1; base_addr = 3'd0; len = 4'd8; bus.out_ready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (bus.out_valid) beats++;
    end
    check("mid beats", beats, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid valid", bus.out_valid, 0);
    check("mid busy", busy, 0);
    check("mid sum", sum, 0);
    check("mid done", done, 0);
    check("mid rom_addr", bus.rom_addr, 0);
    rst = 1'b0;
    vcnt = 0; dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcnt++;
      if (done) dcnt++;
    end
    check("post_rst beats", vcnt, 0);
    check("post_rst done", dcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
